// File: rtl/hwpe_cfg_slice_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_cfg_slice_pkg
//
// Shared types and constants for the HWPE configuration slice.
//   cfg_req_t      : one buffered configuration request (add/wen/wdata/be/id)
//   cfg_rsp_t      : one upstream response (rdata/opc/id)
//   issue_state_e  : states of the downstream issue FSM
//   TIMEOUT_RDATA  : read data returned when a downstream response times out
//
// The struct widths are the package defaults; the top level re-declares the
// same layout with its own parameters so non-default widths work unchanged.
// -----------------------------------------------------------------------------
package hwpe_cfg_slice_pkg;

    localparam int unsigned CFG_ADDR_W = 32;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CFG_ID_W   = 5;
    localparam int unsigned CFG_BE_W   = CFG_DATA_W / 8;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] add;
        logic                  wen;
        logic [CFG_DATA_W-1:0] wdata;
        logic [CFG_BE_W-1:0]   be;
        logic [CFG_ID_W-1:0]   id;
    } cfg_req_t;

    typedef struct packed {
        logic [CFG_DATA_W-1:0] rdata;
        logic                  opc;
        logic [CFG_ID_W-1:0]   id;
    } cfg_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2
    } issue_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/hwpe_cfg_slice_fifo.sv
// -----------------------------------------------------------------------------
// hwpe_cfg_slice_fifo
//
// Synchronous request FIFO with a registered head output.
//
// Parameters:
//   DEPTH    : number of entries (>= 1)
//   entry_t  : stored packed type (defaults to cfg_req_t)
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata this cycle (caller guarantees !full)
//   wdata    : entry to write
//   pop      : drop the head this cycle (caller guarantees !empty)
//   head     : oldest entry, held in its own register (reset to zero)
//   full     : no free entry; a same-cycle pop does not clear it
//   empty    : no stored entry
// -----------------------------------------------------------------------------
module hwpe_cfg_slice_fifo
    import hwpe_cfg_slice_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = cfg_req_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign rd_ptr_nxt = ptr_inc(rd_ptr);
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Head mirrors mem[rd_ptr]. When the FIFO is about to hold a
            // single fresh entry, the write data is forwarded straight in,
            // since mem is not yet written at this edge.
            if (pop) begin
                if (count > CNT_W'(1)) begin
                    head <= mem[rd_ptr_nxt];
                end else if (push) begin
                    head <= wdata;
                end
            end else if (push && (count == '0)) begin
                head <= wdata;
            end
        end
    end

endmodule

// File: rtl/hwpe_cfg_slice.sv
// -----------------------------------------------------------------------------
// hwpe_cfg_slice
//
// Registered decoupling stage between a cluster peripheral-interconnect HWPE
// slot and the configuration slave port of one HWPE wrapper. Requests are
// buffered (DEPTH entries), issued downstream one at a time, and each
// response is returned upstream as a one-cycle pulse tagged with the
// original transaction ID.
//
// Optional feature macro: HWPE_CFG_SLICE_TIMEOUT_EN
//   When defined, a downstream response that has not arrived TIMEOUT_CYCLES
//   cycles after the grant is answered locally with opc=1 and
//   rdata=TIMEOUT_RDATA; a late response then counts as spurious.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_req/s_add/s_wen/s_wdata/s_be/s_id : upstream request (wen=1 is a read)
//   s_gnt                    : upstream grant (combinational: s_req & !full)
//   s_r_valid/s_r_rdata/s_r_opc/s_r_id  : upstream response (registered)
//   m_req/m_add/m_wen/m_wdata/m_be/m_id : request to the HWPE cfg slave
//   m_gnt                    : grant from the HWPE
//   m_r_valid/m_r_rdata/m_r_opc          : response from the HWPE
//   spurious_err             : sticky, set on a response with nothing pending
// -----------------------------------------------------------------------------
module hwpe_cfg_slice
    import hwpe_cfg_slice_pkg::*;
#(
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s_req,
    input  logic [ADDR_WIDTH-1:0]   s_add,
    input  logic                    s_wen,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_be,
    input  logic [ID_WIDTH-1:0]     s_id,
    output logic                    s_gnt,

    output logic                    s_r_valid,
    output logic [DATA_WIDTH-1:0]   s_r_rdata,
    output logic                    s_r_opc,
    output logic [ID_WIDTH-1:0]     s_r_id,

    output logic                    m_req,
    output logic [ADDR_WIDTH-1:0]   m_add,
    output logic                    m_wen,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_be,
    output logic [ID_WIDTH-1:0]     m_id,
    input  logic                    m_gnt,

    input  logic                    m_r_valid,
    input  logic [DATA_WIDTH-1:0]   m_r_rdata,
    input  logic                    m_r_opc,

    output logic                    spurious_err
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Same layout as cfg_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] add;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
        logic [ID_WIDTH-1:0]   id;
    } req_t;

    req_t                fifo_wdata;
    req_t                fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    issue_state_e        state_q;
    issue_state_e        state_d;

    logic                capture;
    logic                spurious;
    logic                tmo_fire;
    logic [ID_WIDTH-1:0] cur_id_q;

    // -------------------------------------------------------------------------
    // Upstream accept and request buffer
    // -------------------------------------------------------------------------
    assign s_gnt = s_req & ~fifo_full;
    assign push  = s_gnt;

    assign fifo_wdata = '{add: s_add, wen: s_wen, wdata: s_wdata, be: s_be, id: s_id};

    hwpe_cfg_slice_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) i_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The registered FIFO head drives the downstream fields directly, so they
    // stay stable for the whole WAIT_GNT stall.
    assign m_add   = fifo_head.add;
    assign m_wen   = fifo_head.wen;
    assign m_wdata = fifo_head.wdata;
    assign m_be    = fifo_head.be;
    assign m_id    = fifo_head.id;

    // -------------------------------------------------------------------------
    // Issue FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            // A push this cycle counts as non-empty: the head register is
            // loaded at the same edge, which gives m_req one cycle after
            // acceptance.
            ST_IDLE: begin
                if (!fifo_empty || push) begin
                    state_d = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                if (m_gnt) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (m_r_valid || tmo_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Issue FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        m_req    = 1'b0;
        pop      = 1'b0;
        capture  = 1'b0;
        spurious = 1'b0;
        case (state_q)
            ST_WAIT_GNT: begin
                m_req    = 1'b1;
                pop      = m_gnt;
                spurious = m_r_valid;
            end
            ST_WAIT_RSP: begin
                capture  = m_r_valid;
            end
            default: begin
                spurious = m_r_valid;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Response timeout
    // -------------------------------------------------------------------------
`ifdef HWPE_CFG_SLICE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // The count starts at 1 on the grant cycle, so it equals the number of
    // cycles since m_gnt. Firing at TIMEOUT_CYCLES-1 places the local
    // response exactly TIMEOUT_CYCLES cycles after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (pop) begin
            tmo_cnt <= TMO_W'(1);
        end else if (state_q == ST_WAIT_RSP) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // A real response in the same cycle wins over the timeout.
    assign tmo_fire = (state_q == ST_WAIT_RSP) && !m_r_valid &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    function automatic logic [DATA_WIDTH-1:0] timeout_rdata();
        return DATA_WIDTH'(TIMEOUT_RDATA);
    endfunction
`else
    logic unused_timeout_cycles;

    assign tmo_fire              = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // -------------------------------------------------------------------------
    // Transaction ID, response register, error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id_q     <= '0;
            s_r_valid    <= 1'b0;
            s_r_rdata    <= '0;
            s_r_opc      <= 1'b0;
            s_r_id       <= '0;
            spurious_err <= 1'b0;
        end else begin
            if (pop) begin
                cur_id_q <= m_id;
            end

            s_r_valid <= 1'b0;
            if (capture) begin
                s_r_valid <= 1'b1;
                s_r_rdata <= m_r_rdata;
                s_r_opc   <= m_r_opc;
                s_r_id    <= cur_id_q;
            end
`ifdef HWPE_CFG_SLICE_TIMEOUT_EN
            else if (tmo_fire) begin
                s_r_valid <= 1'b1;
                s_r_rdata <= timeout_rdata();
                s_r_opc   <= 1'b1;
                s_r_id    <= cur_id_q;
            end
`endif

            if (spurious) begin
                spurious_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_cfg_slice.sv
// -----------------------------------------------------------------------------
// tb_hwpe_cfg_slice
//
// Directed bench for hwpe_cfg_slice (DEPTH=2, 32-bit data, 5-bit ID,
// TIMEOUT_CYCLES=8). Expected upstream responses, including the cycle they
// must appear in, are queued when the stimulus is issued; a negedge monitor
// pops and compares each s_r_valid pulse. Downstream-side fields and flags
// are compared directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_hwpe_cfg_slice;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 5;
    localparam int unsigned TMO   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_req;
    logic [AW-1:0] s_add;
    logic          s_wen;
    logic [DW-1:0] s_wdata;
    logic [DW/8-1:0] s_be;
    logic [IW-1:0] s_id;
    logic          s_gnt;
    logic          s_r_valid;
    logic [DW-1:0] s_r_rdata;
    logic          s_r_opc;
    logic [IW-1:0] s_r_id;
    logic          m_req;
    logic [AW-1:0] m_add;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_be;
    logic [IW-1:0] m_id;
    logic          m_gnt;
    logic          m_r_valid;
    logic [DW-1:0] m_r_rdata;
    logic          m_r_opc;
    logic          spurious_err;

    hwpe_cfg_slice #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (IW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_req        (s_req),
        .s_add        (s_add),
        .s_wen        (s_wen),
        .s_wdata      (s_wdata),
        .s_be         (s_be),
        .s_id         (s_id),
        .s_gnt        (s_gnt),
        .s_r_valid    (s_r_valid),
        .s_r_rdata    (s_r_rdata),
        .s_r_opc      (s_r_opc),
        .s_r_id       (s_r_id),
        .m_req        (m_req),
        .m_add        (m_add),
        .m_wen        (m_wen),
        .m_wdata      (m_wdata),
        .m_be         (m_be),
        .m_id         (m_id),
        .m_gnt        (m_gnt),
        .m_r_valid    (m_r_valid),
        .m_r_rdata    (m_r_rdata),
        .m_r_opc      (m_r_opc),
        .spurious_err (spurious_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        opc;
        logic [4:0]  id;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic opc,
                              input logic [4:0] id, input int at);
        exp_t e;
        e.rdata = rdata;
        e.opc   = opc;
        e.id    = id;
        e.at    = at;
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input logic [31:0] add, input logic wen,
                             input logic [31:0] wdata, input logic [4:0] id);
        s_req   = 1'b1;
        s_add   = add;
        s_wen   = wen;
        s_wdata = wdata;
        s_be    = 4'hF;
        s_id    = id;
    endtask

    // Response monitor: every s_r_valid pulse must match the oldest entry.
    always @(negedge clk) begin
        if (s_r_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got s_r_valid id=%0d rdata=0x%0h, expected no response (cycle %0d)",
                         s_r_id, s_r_rdata, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_rdata", 64'(s_r_rdata), 64'(mon_e.rdata));
                check("rsp_opc",   64'(s_r_opc),   64'(mon_e.opc));
                check("rsp_id",    64'(s_r_id),    64'(mon_e.id));
                check("rsp_cycle", 64'(cyc),       64'(mon_e.at));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    int t0;

    initial begin
        rst       = 1'b1;
        s_req     = 1'b0;
        s_add     = '0;
        s_wen     = 1'b0;
        s_wdata   = '0;
        s_be      = '0;
        s_id      = '0;
        m_gnt     = 1'b0;
        m_r_valid = 1'b0;
        m_r_rdata = '0;
        m_r_opc   = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_s_gnt",     64'(s_gnt),        64'd0);
        check("rst_s_r_valid", 64'(s_r_valid),    64'd0);
        check("rst_s_r_rdata", 64'(s_r_rdata),    64'd0);
        check("rst_s_r_opc",   64'(s_r_opc),      64'd0);
        check("rst_s_r_id",    64'(s_r_id),       64'd0);
        check("rst_m_req",     64'(m_req),        64'd0);
        check("rst_m_fields",  64'({m_add, m_wen, m_be, m_id}), 64'd0);
        check("rst_m_wdata",   64'(m_wdata),      64'd0);
        check("rst_spurious",  64'(spurious_err), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // ---------------- single write, immediate grant ----------------
        t0 = cyc;
        drive_req(32'h10, 1'b0, 32'hA5A5_0001, 5'd3);
        #1 check("wr_s_gnt", 64'(s_gnt), 64'd1);
        tick();
        s_req = 1'b0;
        check("wr_m_req",   64'(m_req),   64'd1);
        check("wr_m_add",   64'(m_add),   64'h10);
        check("wr_m_wen",   64'(m_wen),   64'd0);
        check("wr_m_wdata", 64'(m_wdata), 64'hA5A5_0001);
        check("wr_m_be",    64'(m_be),    64'hF);
        check("wr_m_id",    64'(m_id),    64'd3);
        m_gnt = 1'b1;
        expect_rsp(32'h0, 1'b0, 5'd3, t0 + 3);
        tick();
        m_gnt = 1'b0;
        check("wr_m_req_low", 64'(m_req), 64'd0);
        m_r_valid = 1'b1;
        m_r_rdata = 32'h0;
        tick();
        m_r_valid = 1'b0;
        tick(); tick();
        check("wr_sb_drain", 64'(sb_q.size()), 64'd0);

        // ---------------- single read, 4-cycle grant stall ----------------
        t0 = cyc;
        drive_req(32'h24, 1'b1, 32'h0, 5'd7);
        tick();
        s_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rd_stall_m_req",    64'(m_req), 64'd1);
            check("rd_stall_m_fields", 64'({m_add, m_wen, m_id}), {26'd0, 32'h24, 1'b1, 5'd7});
            tick();
        end
        check("rd_m_req", 64'(m_req), 64'd1);
        m_gnt = 1'b1;
        expect_rsp(32'h1234_5678, 1'b0, 5'd7, t0 + 7);
        tick();
        m_gnt     = 1'b0;
        m_r_valid = 1'b1;
        m_r_rdata = 32'h1234_5678;
        tick();
        m_r_valid = 1'b0;
        m_r_rdata = '0;
        tick(); tick();
        check("rd_sb_drain", 64'(sb_q.size()), 64'd0);

        // ---------------- fill: DEPTH=2, third request back-pressured ----------------
        t0 = cyc;
        drive_req(32'h100, 1'b0, 32'hB000_0000, 5'd0);
        #1 check("fill_gnt0", 64'(s_gnt), 64'd1);
        tick();
        drive_req(32'h104, 1'b0, 32'hB000_0001, 5'd1);
        #1 check("fill_gnt1", 64'(s_gnt), 64'd1);
        tick();
        drive_req(32'h108, 1'b1, 32'hB000_0002, 5'd2);
        #1 check("fill_gnt2_full", 64'(s_gnt), 64'd0);
        check("fill_head0", 64'(m_id), 64'd0);
        tick();
        #1 check("fill_gnt2_nobypass", 64'(s_gnt), 64'd0);
        m_gnt = 1'b1;
        expect_rsp(32'h1000, 1'b0, 5'd0, t0 + 5);
        tick();
        m_gnt = 1'b0;
        #1 check("fill_gnt2_after_pop", 64'(s_gnt), 64'd1);
        m_r_valid = 1'b1;
        m_r_rdata = 32'h1000;
        tick();
        s_req     = 1'b0;
        m_r_valid = 1'b0;
        check("fill_idle_gap", 64'(m_req), 64'd0);
        tick();
        check("fill_m_req1", 64'(m_req), 64'd1);
        check("fill_m_id1",  64'(m_id),  64'd1);
        check("fill_m_add1", 64'(m_add), 64'h104);
        m_gnt = 1'b1;
        expect_rsp(32'h1001, 1'b1, 5'd1, t0 + 8);
        tick();
        m_gnt     = 1'b0;
        m_r_valid = 1'b1;
        m_r_rdata = 32'h1001;
        m_r_opc   = 1'b1;
        tick();
        m_r_valid = 1'b0;
        m_r_opc   = 1'b0;
        tick();
        check("fill_m_req2", 64'(m_req), 64'd1);
        check("fill_m_id2",  64'(m_id),  64'd2);
        check("fill_m_wen2", 64'(m_wen), 64'd1);
        m_gnt = 1'b1;
        expect_rsp(32'h1002, 1'b0, 5'd2, t0 + 11);
        tick();
        m_gnt     = 1'b0;
        m_r_valid = 1'b1;
        m_r_rdata = 32'h1002;
        tick();
        m_r_valid = 1'b0;
        m_r_rdata = '0;
        tick(); tick();
        check("fill_sb_drain", 64'(sb_q.size()), 64'd0);

        // ---------------- spurious response in IDLE ----------------
        check("spur_before", 64'(spurious_err), 64'd0);
        m_r_valid = 1'b1;
        m_r_rdata = 32'h5555_AAAA;
        tick();
        m_r_valid = 1'b0;
        check("spur_set", 64'(spurious_err), 64'd1);
        tick(); tick(); tick();
        check("spur_sticky", 64'(spurious_err), 64'd1);

        // ---------------- reset in WAIT_RSP with one entry queued ----------------
        drive_req(32'h200, 1'b0, 32'hC000_0009, 5'd9);
        tick();
        drive_req(32'h204, 1'b0, 32'hC000_000A, 5'd10);
        m_gnt = 1'b1;
        tick();
        s_req = 1'b0;
        m_gnt = 1'b0;
        check("rstmid_wait_rsp", 64'(m_req), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_m_req",    64'(m_req),        64'd0);
        check("rstmid_spur_clr", 64'(spurious_err), 64'd0);
        check("rstmid_m_id",     64'(m_id),         64'd0);
        m_r_valid = 1'b1;
        m_r_rdata = 32'hC000_0009;
        tick();
        m_r_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstmid_flushed", 64'(m_req), 64'd0);
            tick();
        end
        check("rstmid_late_spur", 64'(spurious_err), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_clears_spur", 64'(spurious_err), 64'd0);

`ifdef HWPE_CFG_SLICE_TIMEOUT_EN
        // ---------------- downstream response timeout ----------------
        drive_req(32'h300, 1'b1, 32'h0, 5'd4);
        tick();
        s_req = 1'b0;
        check("tmo_m_req", 64'(m_req), 64'd1);
        m_gnt = 1'b1;
        expect_rsp(32'hDEAD_BEEF, 1'b1, 5'd4, cyc + TMO);
        tick();
        m_gnt = 1'b0;
        for (int i = 0; i < TMO + 2; i++) tick();
        check("tmo_sb_drain", 64'(sb_q.size()), 64'd0);
        check("tmo_no_spur", 64'(spurious_err), 64'd0);
        m_r_valid = 1'b1;
        tick();
        m_r_valid = 1'b0;
        check("tmo_late_spur", 64'(spurious_err), 64'd1);
`endif

        tick(); tick();
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
